// File: rtl/mem_port_arb_pkg.sv
// Shared types and default widths for the unified IF/MEM memory port arbiter.
package mem_port_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TMO_CYC_DEF = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_REQ  = 3'd1,
    IF_WAIT = 3'd2,
    DM_REQ  = 3'd3,
    DM_WAIT = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arb_wdog.sv
// Transaction watchdog: counts busy cycles, expires on the TMO_CYC-th one.
// Instantiated by mem_port_arbiter only when MEM_PORT_ARB_TMO_EN is defined.
module mem_port_arb_wdog #(
  parameter int unsigned TMO_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expire
);

  localparam int unsigned CntW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [CntW-1:0] r_cnt;

  // Count value 0 is the first busy cycle, so TMO_CYC-1 marks the last allowed one.
  assign o_expire = i_run & (r_cnt == CntW'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_run && !o_expire) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time.
// Define MEM_PORT_ARB_TMO_EN to add the watchdog and sticky err output.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_valid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
`ifdef MEM_PORT_ARB_TMO_EN
  output logic                err,
`endif
  output logic                busy
);

  arb_state_t          r_state;
  arb_state_t          w_state_d;
  logic                r_drop;
  logic                w_drop_d;
  logic                r_we;
  logic [DATA_W/8-1:0] r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_start_if;
  logic                w_start_dm;
  logic                w_in_req;
  logic                w_in_wait;
  owner_t              w_owner;
  logic                w_if_resp;
  logic                w_dm_resp;
  logic                w_expire;

  assign w_in_req  = (r_state == IF_REQ) || (r_state == DM_REQ);
  assign w_in_wait = (r_state == IF_WAIT) || (r_state == DM_WAIT);
  assign w_owner   = ((r_state == DM_REQ) || (r_state == DM_WAIT)) ? OWN_DM : OWN_IF;
  assign busy      = (r_state != IDLE);

  always_comb begin
    w_state_d  = r_state;
    w_drop_d   = r_drop;
    w_start_if = 1'b0;
    w_start_dm = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (dm_req) begin
          w_state_d  = DM_REQ;
          w_start_dm = 1'b1;
        end else if (if_req && !if_flush) begin
          w_state_d  = IF_REQ;
          w_start_if = 1'b1;
        end
      end
      IF_REQ: begin
        if (if_flush) w_drop_d = 1'b1;
        if (mem_gnt)  w_state_d = IF_WAIT;
      end
      IF_WAIT: begin
        if (if_flush)   w_drop_d = 1'b1;
        if (mem_rvalid) w_state_d = IDLE;
      end
      DM_REQ: begin
        if (mem_gnt) w_state_d = DM_WAIT;
      end
      DM_WAIT: begin
        if (mem_rvalid) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
    if (w_expire) w_state_d = IDLE;
    if (w_state_d == IDLE) w_drop_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_drop  <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_d;
      r_drop  <= w_drop_d;
      if (w_start_dm) begin
        r_we    <= dm_we;
        r_be    <= dm_be;
        r_addr  <= dm_addr;
        r_wdata <= dm_wdata;
      end else if (w_start_if) begin
        r_we    <= 1'b0;
        r_be    <= {(DATA_W/8){1'b1}};
        r_addr  <= if_addr;
        r_wdata <= '0;
      end
    end
  end

  // Request fields are only presented while a request is pending.
  assign mem_req   = w_in_req;
  assign mem_we    = w_in_req & r_we;
  assign mem_be    = w_in_req ? r_be : '0;
  assign mem_addr  = w_in_req ? r_addr : '0;
  assign mem_wdata = w_in_req ? r_wdata : '0;

  assign w_if_resp = busy && (w_owner == OWN_IF) && ((w_in_wait && mem_rvalid) || w_expire);
  assign w_dm_resp = busy && (w_owner == OWN_DM) && ((w_in_wait && mem_rvalid) || w_expire);

  assign if_valid  = w_if_resp & ~r_drop & ~if_flush;
  assign dm_valid  = w_dm_resp;
  assign if_rdata  = (if_valid && !w_expire) ? mem_rdata : '0;
  assign dm_rdata  = (dm_valid && !w_expire) ? mem_rdata : '0;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

`ifdef MEM_PORT_ARB_TMO_EN
  logic r_err;

  mem_port_arb_wdog #(
    .TMO_CYC (TMO_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (busy),
    .i_clr    (~busy),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_tmo;

  assign w_expire     = 1'b0;
  assign w_unused_tmo = ^TMO_CYC;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; covers the watchdog when MEM_PORT_ARB_TMO_EN is set.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        busy;
`ifdef MEM_PORT_ARB_TMO_EN
  logic        err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TMO_CYC (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_valid   (if_valid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_valid   (dm_valid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
`ifdef MEM_PORT_ARB_TMO_EN
    .err        (err),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    nxt(); nxt();
    smp();
    chk("rst_busy", busy, 0);
    chk("rst_mem", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 0);
    chk("rst_valids", {if_valid, dm_valid, if_rdata, dm_rdata}, 0);
`ifdef MEM_PORT_ARB_TMO_EN
    chk("rst_err", err, 0);
`endif
    nxt();
    rst_n = 1'b1;
    nxt();

    // Fetch without contention
    if_req = 1'b1; if_addr = 32'h100;
    smp();
    chk("f1_idle", {busy, mem_req, stall_if}, 3'b001);
    nxt();
    mem_gnt = 1'b1;
    smp();
    chk("f1_req", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h100});
    chk("f1_req_stall", {stall_if, if_valid}, 2'b10);
    nxt();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    smp();
    chk("f1_wait", {mem_req, if_valid, stall_if, if_rdata}, {3'b010, 32'h0050_0093});
    nxt();
    if_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    chk("f1_done", {busy, if_valid, if_rdata}, 0);
    nxt();

    // Simultaneous fetch and load: load goes first
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h2000;
    smp();
    chk("c_idle_stall", {stall_if, stall_mem}, 2'b11);
    nxt();
    mem_gnt = 1'b1;
    smp();
    chk("c_dm_req", {mem_req, mem_we, mem_addr, stall_if}, {1'b1, 1'b0, 32'h2000, 1'b1});
    nxt();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    smp();
    chk("c_dm_resp", {dm_valid, stall_mem, stall_if, if_valid, dm_rdata},
        {4'b1010, 32'h1122_3344});
    nxt();
    dm_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    chk("c_idle2", {busy, stall_if}, 2'b01);
    nxt();
    mem_gnt = 1'b1;
    smp();
    chk("c_if_req", {mem_req, mem_addr, stall_if}, {1'b1, 32'h100, 1'b1});
    nxt();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
    smp();
    chk("c_if_resp", {if_valid, dm_valid, if_rdata}, {2'b10, 32'hAAAA_5555});
    nxt();
    if_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    nxt();

    // Store with grant on the 4th request cycle; request fields must hold steady
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF;
    nxt();
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      smp();
      chk($sformatf("st_req%0d", i), {mem_req, mem_we, mem_be, mem_addr, mem_wdata, dm_valid},
          {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF, 1'b0});
      nxt();
      dm_addr = 32'hFFFF_0000; dm_wdata = 32'h0BAD_F00D;
    end
    mem_gnt = 1'b0;
    smp();
    chk("st_wait", {mem_req, dm_valid, stall_mem, busy}, 4'b0011);
    nxt();
    mem_rvalid = 1'b1; mem_rdata = '0;
    smp();
    chk("st_ack", {dm_valid, stall_mem, dm_rdata}, {2'b10, 32'h0});
    nxt();
    dm_req = 1'b0; dm_we = 1'b0; mem_rvalid = 1'b0;
    nxt();

    // Flush while in IDLE: no fetch issued
    if_req = 1'b1; if_addr = 32'h200; if_flush = 1'b1;
    nxt();
    if_flush = 1'b0; if_req = 1'b0;
    smp();
    chk("fl_idle", {busy, mem_req}, 2'b00);
    nxt();

    // Flush in IF_WAIT: response suppressed, next fetch uses new address
    if_req = 1'b1; if_addr = 32'h300;
    nxt();
    mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; if_flush = 1'b1;
    smp();
    chk("fl_pulse", {if_valid, busy}, 2'b01);
    nxt();
    if_flush = 1'b0; if_addr = 32'h400;
    nxt();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    smp();
    chk("fl_resp", {if_valid, stall_if, if_rdata}, {2'b01, 32'h0});
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    chk("fl_idle2", {busy, stall_if}, 2'b01);
    nxt();
    mem_gnt = 1'b1;
    smp();
    chk("fl_new_addr", {mem_req, mem_addr}, {1'b1, 32'h400});
    nxt();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    smp();
    chk("fl_new_resp", {if_valid, if_rdata}, {1'b1, 32'h0000_0013});
    nxt();
    if_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    nxt();

    // Reset during DM_WAIT, then a stray response
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h2008;
    nxt();
    mem_gnt = 1'b1;
    nxt();
    mem_gnt = 1'b0; rst_n = 1'b0;
    smp();
    chk("rm_before", {busy, mem_req, dm_valid}, 3'b100);
    nxt();
    rst_n = 1'b1; dm_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    smp();
    chk("rm_after", {busy, mem_req, dm_valid, if_valid, dm_rdata, if_rdata}, 0);
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    chk("rm_stray", {busy, dm_valid}, 2'b00);
    nxt();

`ifdef MEM_PORT_ARB_TMO_EN
    // Grant never arrives: watchdog fires on the 8th busy cycle
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h3000; mem_rdata = 32'h5A5A_5A5A;
    nxt();
    for (int i = 0; i < 7; i++) begin
      smp();
      chk($sformatf("to_wait%0d", i), {mem_req, dm_valid, err}, 3'b100);
      nxt();
    end
    smp();
    chk("to_fire", {dm_valid, dm_rdata, err}, {1'b1, 32'h0, 1'b0});
    nxt();
    dm_req = 1'b0; mem_rdata = '0;
    smp();
    chk("to_after", {busy, mem_req, dm_valid, err}, 4'b0001);
    nxt();
    smp();
    chk("to_sticky", err, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
